// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared op codes and FSM state encodings for the JK bank sequencer.
//   op_t    : LOAD / CLEAR / UP / DOWN command codes
//   state_t : IDLE / EXEC / DONE controller states
package jk_seq_pkg;
    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/jk_bit.sv
// jk_bit: single JK flip-flop with asynchronous active-low reset.
//   clk   : rising-edge clock
//   rst_n : async active-low reset, clears q
//   j, k  : 00 hold, 01 reset, 10 set, 11 toggle
//   q     : stored bit
module jk_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);
    logic r_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= (j & ~r_q) | (~k & r_q);
    end
    assign q = r_q;
endmodule

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven controller sequencing a bank of W JK flip-flops.
//   clk, rst_n         : rising-edge clock, async active-low reset
//   cmd_valid/ready    : command handshake, accepted only in IDLE
//   cmd_op/data/len    : operation, load value, count steps
//   abort              : cut the running command short (EXEC only)
//   j, k               : drive currently applied to the bank
//   q                  : bank state
//   busy, done, aborted: EXEC indicator, completion pulse, abort qualifier
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int W  = 4,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [W-1:0]  cmd_data,
    input  logic [LW-1:0] cmd_len,
    input  logic          abort,
    output logic [W-1:0]  j,
    output logic [W-1:0]  k,
    output logic [W-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic          aborted
);
    state_t        r_state, w_next;
    op_t           r_op;
    logic [W-1:0]  r_data;
    logic [LW-1:0] r_len, r_cnt;
    logic          r_aborted;
    logic          w_accept, w_count_op;
    logic [LW-1:0] w_cnt_nx;
    logic [W-1:0]  w_up_t, w_dn_t;

    assign w_accept   = (r_state == IDLE) && cmd_valid;
    assign w_count_op = (r_op == OP_UP) || (r_op == OP_DOWN);
    assign w_cnt_nx   = r_cnt + LW'(1);
    // Bits that flip on increment/decrement are exactly those whose lower bits are all ones/zeros.
    assign w_up_t = q ^ (q + W'(1));
    assign w_dn_t = q ^ (q - W'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (cmd_valid)
                      w_next = (cmd_op[1] && cmd_len == '0) ? DONE : EXEC;
            EXEC: if (abort || !w_count_op || w_cnt_nx == r_len)
                      w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        j = '0;
        k = '0;
        if (r_state == EXEC && !abort) begin
            case (r_op)
                OP_LOAD:  begin j = r_data; k = ~r_data; end
                OP_CLEAR: k = '1;
                OP_UP:    begin j = w_up_t; k = w_up_t; end
                default:  begin j = w_dn_t; k = w_dn_t; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= OP_LOAD;
            r_data    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op      <= op_t'(cmd_op);
                r_data    <= cmd_data;
                r_len     <= cmd_len;
                r_cnt     <= '0;
                r_aborted <= 1'b0;
            end else if (r_state == EXEC) begin
                r_cnt     <= w_cnt_nx;
                r_aborted <= abort;
            end
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state == EXEC);
    assign done      = (r_state == DONE);
    assign aborted   = done && r_aborted;

    for (genvar g = 0; g < W; g++) begin : g_bank
        jk_bit u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .j    (j[g]),
            .k    (k[g]),
            .q    (q[g])
        );
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: scoreboard bench; the driver predicts each command's final q,
// abort flag and done cycle with plain modular arithmetic, the monitor checks them on done.
module tb_jk_bank_sequencer;
    localparam int W  = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [W-1:0]  cmd_data = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          abort = 1'b0;
    logic [W-1:0]  j, k, q;
    logic          busy, done, aborted;

    jk_bank_sequencer #(.W(W), .LW(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_len  (cmd_len),
        .abort    (abort),
        .j        (j),
        .k        (k),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int ab;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mq = 0;
    bit   idle_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (idle_chk) begin
                chk("idle_after_done", {cmd_ready, busy, done}, 3'b100);
                idle_chk = 0;
            end
            if (done) begin
                if (sb.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("q_at_done", q, e.q);
                    chk("aborted", aborted, e.ab);
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_status", {cmd_ready, busy, j, k}, 0);
                    idle_chk = 1;
                end
            end else chk("aborted_without_done", aborted, 0);
        end
    end

    // Issue one command; abort_at is the 1-based EXEC cycle to raise abort in (0 = none).
    task automatic issue(input int op, input int data, input int len, input int abort_at);
        int nexec, steps, lat, ab, t;
        exp_t e;
        t = 0;
        while (!cmd_ready && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        nexec = (op < 2) ? 1 : len;
        if (abort_at >= 1 && abort_at <= nexec) begin
            steps = abort_at - 1;
            ab    = 1;
            lat   = abort_at + 1;
        end else begin
            steps = nexec;
            ab    = 0;
            lat   = nexec + 1;
        end
        if (op == 0 && steps > 0) mq = data;
        else if (op == 1 && steps > 0) mq = 0;
        else if (op == 2) mq = (mq + steps) & 15;
        else if (op == 3) mq = (mq - steps) & 15;
        e.q = mq;
        e.ab = ab;
        e.cyc = cyc + lat;
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_data  = data[W-1:0];
        cmd_len   = len[LW-1:0];
        @(negedge clk);
        cmd_valid = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {q, cmd_ready, busy, done, aborted, j, k}, 16'h0800);

        issue(0, 4'b1010, 0, 0);
        issue(0, 4'b1110, 0, 0);
        issue(2, 0, 3, 0);
        issue(1, 0, 0, 0);
        issue(3, 0, 2, 0);
        issue(2, 0, 0, 0);
        issue(1, 0, 0, 0);
        issue(2, 0, 10, 4);

        issue(0, 4'b0101, 0, 0);
        issue(2, 0, 10, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_q", q, 0);
        chk("async_reset_status", {cmd_ready, busy, done}, 3'b100);
        sb.delete();
        mq = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 4'b0110, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int op, len, a;
            op  = $urandom_range(0, 3);
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 12);
            a   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ((op < 2) ? 1 : len) + 2) : 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, $urandom_range(0, 15), len, a);
        end

        for (int i = 0; i < 600 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
